// File: rtl/max7219_pkg.sv
// max7219_pkg: shared register addresses, FSM state encoding and a small
// index-search helper for the MAX7219 command scheduler.
package max7219_pkg;

    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

    localparam logic [3:0] INIT_LAST      = 4'd5;
    localparam logic [3:0] INIT_IDX_INT   = 4'd4;
    // Digit index value meaning "no digit left to send".
    localparam logic [3:0] IDX_NONE       = 4'd8;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_REFRESH = 2'd1,
        ST_INTENS  = 2'd2,
        ST_IDLE    = 2'd3
    } state_t;

    // Lowest set bit of mask at or above 'from'; IDX_NONE if there is none.
    function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = IDX_NONE;
        for (int i = 7; i >= 0; i--) begin
            if ((4'(i) >= from) && mask[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/max7219_init_rom.sv
// max7219_init_rom: combinational map from init step (0..5) to the command
// word sent to the MAX7219 during power-up configuration.
module max7219_init_rom
    import max7219_pkg::*;
#(
    parameter int SCAN_LIMIT = 7
) (
    input  logic [2:0]  idx_i,
    input  logic [3:0]  intensity_i,
    output logic [15:0] word_o
);

    // Shutdown, test off, full code-B decode, scan limit, brightness, run.
    always_comb begin
        word_o = 16'h0000;
        case (idx_i)
            3'd0: word_o = {4'h0, ADDR_SHUTDOWN,  8'h00};
            3'd1: word_o = {4'h0, ADDR_DISPTEST,  8'h00};
            3'd2: word_o = {4'h0, ADDR_DECODE,    8'hFF};
            3'd3: word_o = {4'h0, ADDR_SCANLIM,   8'(SCAN_LIMIT)};
            3'd4: word_o = {4'h0, ADDR_INTENSITY, 4'h0, intensity_i};
            3'd5: word_o = {4'h0, ADDR_SHUTDOWN,  8'h01};
            default: word_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/max7219_sched.sv
// max7219_sched: sequences MAX7219 command words (init, digit refresh,
// brightness updates) into a valid/ready SPI serializer interface.
// Optional build macro MAX7219_DIRTY_SKIP_EN: keep a shadow of the last
// value sent per digit and skip digits that did not change.
//
// state   | meaning
// INIT    | sending the six power-up configuration words
// REFRESH | sending digit words from the snapshot taken on entry
// INTENS  | sending a brightness update
// IDLE    | nothing to send; waits for intensity change or refresh request
module max7219_sched
    import max7219_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_LIMIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic        upd_req,
    input  logic [3:0]  intensity,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        init_done
);

    localparam logic [7:0] DIGIT_MASK = 8'((1 << NUM_DIGITS) - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic        init_done_q, init_done_d;
    logic [3:0]  last_int_q, last_int_d;
    logic [3:0]  int_word_q, int_word_d;
    logic [31:0] snap_dig_q, snap_dig_d;
    logic [7:0]  snap_dp_q, snap_dp_d;
    logic [15:0] rom_word, word;
    logic        valid, xfer, enter_ref;
    logic [7:0]  mask_snap, mask_in;
    logic [3:0]  nxt_idx;

    max7219_init_rom #(.SCAN_LIMIT(SCAN_LIMIT)) u_rom (
        .idx_i       (idx_q[2:0]),
        .intensity_i (int_word_q),
        .word_o      (rom_word)
    );

`ifdef MAX7219_DIRTY_SKIP_EN
    logic [39:0] shadow_q, shadow_d;
    logic [7:0]  shv_q, shv_d;

    // Digits needing a send: never sent since init, or value differs from shadow.
    always_comb begin
        mask_snap = 8'h00;
        mask_in   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mask_snap[i] = DIGIT_MASK[i] &
                (!shv_q[i] || (shadow_q[i*5 +: 5] != {snap_dp_q[i], snap_dig_q[i*4 +: 4]}));
            mask_in[i]   = DIGIT_MASK[i] &
                (!shv_q[i] || (shadow_q[i*5 +: 5] != {dp_in[i], digits_in[i*4 +: 4]}));
        end
    end
`else
    // Every configured digit is sent on each refresh.
    always_comb begin
        mask_snap = DIGIT_MASK;
        mask_in   = DIGIT_MASK;
    end
`endif

    assign xfer    = valid && tx_ready && !rst;
    assign nxt_idx = next_set(mask_snap, idx_q + 4'd1);

    // Next-state, word selection and bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q | upd_req;
        init_done_d = init_done_q;
        last_int_d  = last_int_q;
        int_word_d  = int_word_q;
        snap_dig_d  = snap_dig_q;
        snap_dp_d   = snap_dp_q;
        word        = 16'h0000;
        valid       = 1'b0;
        enter_ref   = 1'b0;
`ifdef MAX7219_DIRTY_SKIP_EN
        shadow_d    = shadow_q;
        shv_d       = shv_q;
`endif
        case (state_q)
            ST_INIT: begin
                valid = 1'b1;
                word  = rom_word;
                if (xfer) begin
                    if (idx_q == INIT_IDX_INT) last_int_d = int_word_q;
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        enter_ref   = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_REFRESH: begin
                if (idx_q == IDX_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    valid = 1'b1;
                    word  = {4'h0, idx_q + ADDR_DIGIT0, snap_dp_q[idx_q[2:0]], 3'b000,
                             snap_dig_q[{idx_q[2:0], 2'b00} +: 4]};
                    if (xfer) begin
`ifdef MAX7219_DIRTY_SKIP_EN
                        shadow_d[idx_q[2:0]*5 +: 5] = word[7:0] == 8'h00 ? 5'h00 :
                                                      {word[7], word[3:0]};
                        shv_d[idx_q[2:0]]           = 1'b1;
`endif
                        idx_d = nxt_idx;
                        if (nxt_idx == IDX_NONE) state_d = ST_IDLE;
                    end
                end
            end
            ST_INTENS: begin
                valid = 1'b1;
                word  = {4'h0, ADDR_INTENSITY, 4'h0, int_word_q};
                if (xfer) begin
                    last_int_d = int_word_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                if (intensity != last_int_q) state_d = ST_INTENS;
                else if (pend_q)             enter_ref = 1'b1;
            end
        endcase

        if (enter_ref) begin
            state_d    = ST_REFRESH;
            snap_dig_d = digits_in;
            snap_dp_d  = dp_in;
            idx_d      = next_set(mask_in, 4'd0);
            pend_d     = upd_req;
        end

        // Track the live brightness except while it is on the bus, so the word holds.
        if (!(((state_q == ST_INIT) && (idx_q == INIT_IDX_INT)) || (state_q == ST_INTENS)))
            int_word_d = intensity;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            idx_q       <= 4'd0;
            pend_q      <= 1'b0;
            init_done_q <= 1'b0;
            last_int_q  <= 4'h0;
            int_word_q  <= 4'h0;
            snap_dig_q  <= 32'h0;
            snap_dp_q   <= 8'h0;
`ifdef MAX7219_DIRTY_SKIP_EN
            shadow_q    <= 40'h0;
            shv_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            last_int_q  <= last_int_d;
            int_word_q  <= int_word_d;
            snap_dig_q  <= snap_dig_d;
            snap_dp_q   <= snap_dp_d;
`ifdef MAX7219_DIRTY_SKIP_EN
            shadow_q    <= shadow_d;
            shv_q       <= shv_d;
`endif
        end
    end

    assign tx_valid  = valid && !rst;
    assign tx_data   = rst ? 16'h0000 : word;
    assign init_done = init_done_q && !rst;
    assign busy      = !rst && ((state_q != ST_IDLE) || pend_q || (intensity != last_int_q));

endmodule

// File: tb/tb_max7219_sched.sv
// tb_max7219_sched: directed bench for max7219_sched (both build variants).
module tb_max7219_sched;

    typedef logic [15:0] wl_t [8];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic        upd_req;
    logic [3:0]  intensity;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        init_done;

    int tests = 0;
    int fails = 0;

    max7219_sched #(.NUM_DIGITS(8), .SCAN_LIMIT(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .upd_req   (upd_req),
        .intensity (intensity),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a valid word, check it, then let it transfer if ready.
    task automatic take(input logic [15:0] exp, input string tag, input bit consec);
        int n;
        n = 0;
        while (!tx_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, {15'b0, tx_valid}, 16'h0001);
        chk(tag, tx_data, exp);
        if (consec) chk({tag, "_gap"}, 16'(n), 16'h0000);
        if (tx_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic take_seq(input wl_t w, input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) take(w[i], $sformatf("%s%0d", tag, i), i != 0);
    endtask

    task automatic pulse_upd();
        upd_req = 1'b1;
        @(posedge clk); #1;
        upd_req = 1'b0;
    endtask

    task automatic quiet(input int cyc, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk); #1;
            if (tx_valid) cnt++;
        end
        chk({tag, "_nowords"}, 16'(cnt), 16'h0000);
        chk({tag, "_busy"}, {15'b0, busy}, 16'h0000);
    endtask

    initial begin
        wl_t ref0, ref33, ref35a, ref35b, ref36, refrst;
        ref0   = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
        ref33  = '{16'h0180, 16'h0201, 16'h0302, 16'h0403, 16'h0504, 16'h0605, 16'h0706, 16'h0807};
        ref35a = '{16'h0107, 16'h0206, 16'h0305, 16'h0404, 16'h0503, 16'h0602, 16'h0701, 16'h0800};
        ref35b = '{16'h0108, 16'h0206, 16'h0305, 16'h0404, 16'h0503, 16'h0602, 16'h0701, 16'h0800};
        ref36  = '{16'h0108, 16'h0206, 16'h0305, 16'h0404, 16'h0503, 16'h0609, 16'h0701, 16'h0800};
        refrst = '{16'h0107, 16'h0206, 16'h0305, 16'h0404, 16'h0503, 16'h0609, 16'h0701, 16'h0800};

        rst = 1'b1; digits_in = 32'h0; dp_in = 8'h0; upd_req = 1'b0;
        intensity = 4'h8; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {15'b0, tx_valid}, 16'h0000);
        chk("rst_data", tx_data, 16'h0000);
        chk("rst_busy", {15'b0, busy}, 16'h0000);
        chk("rst_done", {15'b0, init_done}, 16'h0000);

        // Init sequence with a 5-cycle stall on the third word.
        @(negedge clk); rst = 1'b0; #1;
        take(16'h0C00, "init0", 1'b1);
        take(16'h0F00, "init1", 1'b1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", tx_data, 16'h09FF);
            chk("stall_valid", {15'b0, tx_valid}, 16'h0001);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        take(16'h09FF, "init2", 1'b1);
        take(16'h0B07, "init3", 1'b1);
        take(16'h0A08, "init4", 1'b1);
        chk("done_low", {15'b0, init_done}, 16'h0000);
        take(16'h0C01, "init5", 1'b1);
        chk("done_high", {15'b0, init_done}, 16'h0001);
        take(ref0[0], "ref0_0", 1'b1);
        for (int i = 1; i < 8; i++) take(ref0[i], $sformatf("ref0_%0d", i), 1'b1);
        quiet(4, "after_init");

        // Refresh with new digits and a decimal point on digit 0.
        digits_in = 32'h76543210; dp_in = 8'h01;
        pulse_upd();
        chk("req_busy", {15'b0, busy}, 16'h0001);
        take_seq(ref33, 8, "ref33_");
        quiet(4, "after33");

        // Intensity change and request together: brightness goes first.
        intensity = 4'h3;
        pulse_upd();
        chk("int_busy", {15'b0, busy}, 16'h0001);
        take(16'h0A03, "intens", 1'b0);
`ifndef MAX7219_DIRTY_SKIP_EN
        take_seq(ref33, 8, "ref34_");
`endif
        quiet(4, "after34");

        // Three requests during a refresh coalesce; digits change after the snapshot.
        digits_in = 32'h01234567; dp_in = 8'h00;
        pulse_upd();
        for (int k = 0; k < 8; k++) begin
            upd_req = (k >= 1 && k <= 3);
            if (k == 1) digits_in = 32'h01234568;
            take(ref35a[k], $sformatf("ref35a_%0d", k), k != 0);
        end
        upd_req = 1'b0;
`ifdef MAX7219_DIRTY_SKIP_EN
        take(16'h0108, "ref35b_skip", 1'b0);
`else
        take_seq(ref35b, 8, "ref35b_");
`endif
        quiet(40, "after35");

        // Only digit 5 changes.
        digits_in = 32'h01934568;
        pulse_upd();
`ifdef MAX7219_DIRTY_SKIP_EN
        take(16'h0609, "ref36_skip", 1'b0);
`else
        take_seq(ref36, 8, "ref36_");
`endif
        quiet(10, "after36");

        // Reset while a word is stalled on the bus, then full restart.
        digits_in = 32'h01934567;
        tx_ready  = 1'b0;
        pulse_upd();
        take(16'h0107, "pre_rst", 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {15'b0, tx_valid}, 16'h0000);
        chk("midrst_data", tx_data, 16'h0000);
        chk("midrst_done", {15'b0, init_done}, 16'h0000);
        chk("midrst_busy", {15'b0, busy}, 16'h0000);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        take(16'h0C00, "re_init0", 1'b1);
        take(16'h0F00, "re_init1", 1'b1);
        take(16'h09FF, "re_init2", 1'b1);
        take(16'h0B07, "re_init3", 1'b1);
        take(16'h0A03, "re_init4", 1'b1);
        take(16'h0C01, "re_init5", 1'b1);
        chk("re_done", {15'b0, init_done}, 16'h0001);
        take_seq(refrst, 8, "refrst_");
        quiet(10, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/max7219_sched.md
MAX7219_SCHED -- requirements
Module: max7219_sched

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of digit registers refreshed (1..8).
REQ-002 Parameter SCAN_LIMIT, default 7, value written to the MAX7219 scan-limit register.
REQ-003 clk  in  1  system clock (50 MHz).
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 digits_in  in  32  eight 4-bit code-B digits; digit i at [4i+3:4i].
REQ-006 dp_in  in  8  decimal-point bits; bit i belongs to digit i.
REQ-007 upd_req  in  1  one-cycle pulse requesting a display refresh from digits_in/dp_in.
REQ-008 intensity  in  4  brightness; any change is written to the MAX7219.
REQ-009 tx_data  out  16  command word {4'h0, addr[3:0], data[7:0]} to the SPI serializer.
REQ-010 tx_valid  out  1  tx_data is valid.
REQ-011 tx_ready  in  1  serializer accepts the word.
REQ-012 busy  out  1  high while a sequence is active or a request is pending.
REQ-013 init_done  out  1  high once the init sequence has completed.

Function
REQ-014 A transfer SHALL occur on a rising edge where tx_valid and tx_ready are both high; tx_data SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-015 The next word SHALL be presented, if any, in the cycle after a transfer; tx_valid SHALL never drop without a transfer.
REQ-016 States SHALL be INIT, REFRESH, INTENS and IDLE; INIT is entered in the first cycle after rst is released.
REQ-017 INIT SHALL send in order: 0x0C00, 0x0F00, 0x09FF, 0x0B00|SCAN_LIMIT, 0x0A00|intensity, 0x0C01.
REQ-018 init_done SHALL rise in the cycle after 0x0C01 is transferred and stay high until reset; the FSM then enters REFRESH.
REQ-019 REFRESH SHALL snapshot digits_in/dp_in on entry and send digit i = 0..NUM_DIGITS-1 as addr i+1, data {dp[i], 3'b000, digit[i]}, in ascending order.
REQ-020 IDLE SHALL leave to INTENS when intensity differs from the last value written, else to REFRESH when a request is pending.
REQ-021 INTENS SHALL send 0x0A00|intensity and record that value as written.
REQ-022 upd_req received in any state SHALL set a pending flag; multiple requests before service SHALL coalesce into one refresh, which uses the values sampled at REFRESH entry.
REQ-023 A pending intensity change and a pending refresh SHALL be served intensity first.
REQ-024 busy SHALL equal (state != IDLE) OR pending OR (intensity differs from the last value written).

Reset
REQ-025 While rst is high: tx_valid=0, tx_data=16'h0000, init_done=0, busy=0, pending cleared, last-written intensity=0.
REQ-026 rst asserted mid-sequence SHALL deassert tx_valid on the next edge, abandon the current word, and restart from INIT after release.

Configuration
REQ-027 With MAX7219_DIRTY_SKIP_EN defined, REFRESH SHALL send only digits whose {dp, digit} differs from the last transferred value; the first refresh after INIT sends all digits; if no digit differs, the FSM returns to IDLE with no transfer.
REQ-028 Without MAX7219_DIRTY_SKIP_EN, every REFRESH SHALL send all NUM_DIGITS words and no shadow registers SHALL be built.

Structure
REQ-029 A shared package max7219_pkg SHALL hold register address constants (DIGIT0=1, DECODE=9, INTENSITY=A, SCANLIM=B, SHUTDOWN=C, DISPTEST=F) and the FSM state enum.
REQ-030 A single sub-module, max7219_init_rom, SHALL map an init index 0..5 to its command word combinationally.

Verification
REQ-031 Release rst with tx_ready=1 and intensity=4'h8 -> words 0C00, 0F00, 09FF, 0B07, 0A08, 0C01 on 6 consecutive edges, then 0100..0800, then busy=0.
REQ-032 Hold tx_ready=0 for 5 cycles during INIT -> tx_data is held at the same word, then the sequence resumes unchanged.
REQ-033 In IDLE, digits_in=32'h76543210, dp_in=8'h01, pulse upd_req -> 0180, 0201, ..., 0807.
REQ-034 Change intensity to 4'h3 and pulse upd_req in the same cycle -> 0A03 is sent before 0180.
REQ-035 Three upd_req pulses during REFRESH -> exactly one further refresh.
REQ-036 Build with MAX7219_DIRTY_SKIP_EN, change only digit 5 to 9 and pulse upd_req -> single word 0609; assert rst mid-transfer -> tx_valid=0 on the next edge and INIT restarts.
